// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access stage.
//   MemType   - access type carried with each load/store
//   MauState  - memory stage controller states
//   memt_size / memt_signed / memt_wide - access type decoders
package mem_access_unit_pkg;

    typedef enum logic [3:0] {
        LoadByte,
        LoadHalf,
        LoadWord,
        ULoadByte,
        ULoadHalf,
        StoreByte,
        StoreHalf,
        StoreWord,
        LoadDouble,
        ULoadWord,
        StoreDouble
    } MemType;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RESP0,
        REQ1,
        RESP1,
        OUT
    } MauState;

    // Access size in bytes (1, 2, 4 or 8).
    function automatic logic [3:0] memt_size(input MemType t);
        case (t)
            LoadByte, ULoadByte, StoreByte: return 4'd1;
            LoadHalf, ULoadHalf, StoreHalf: return 4'd2;
            LoadWord, ULoadWord, StoreWord: return 4'd4;
            default:                        return 4'd8;
        endcase
    endfunction

    // Loads that sign-extend their result.
    function automatic logic memt_signed(input MemType t);
        case (t)
            LoadByte, LoadHalf, LoadWord, LoadDouble: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Types that only exist on a 64-bit datapath.
    function automatic logic memt_wide(input MemType t);
        case (t)
            LoadDouble, ULoadWord, StoreDouble: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
//   memt      - access type (size / signedness)
//   off       - byte offset of the access within a bus word
//   st_data   - register store data
//   st_lo/hi  - store data in lane position for beat0 / beat1
//   strb_lo/hi- byte enables for beat0 / beat1
//   beat0/1   - read data returned by the two bus beats
//   ld_data   - extracted, extended load result
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUS_BYTES = 4,
    localparam int unsigned OFFW     = $clog2(BUS_BYTES),
    localparam int unsigned BW       = 8 * BUS_BYTES
) (
    input  MemType                 memt,
    input  logic [OFFW-1:0]        off,
    input  logic [XLEN-1:0]        st_data,
    output logic [BW-1:0]          st_lo,
    output logic [BW-1:0]          st_hi,
    output logic [BUS_BYTES-1:0]   strb_lo,
    output logic [BUS_BYTES-1:0]   strb_hi,
    input  logic [BW-1:0]          beat0,
    input  logic [BW-1:0]          beat1,
    output logic [XLEN-1:0]        ld_data
);

    logic [2*BW-1:0]        st_vec;
    logic [2*BW-1:0]        ld_vec;
    logic [2*BUS_BYTES-1:0] size_mask;
    logic [2*BUS_BYTES-1:0] strb_vec;
    logic [XLEN-1:0]        ld_raw;
    logic [3:0]             size;
    logic [6:0]             nbits;
    logic                   sgn;
    logic                   sign_bit;

    always_comb begin
        size   = memt_size(memt);
        sgn    = memt_signed(memt);
        nbits  = {size, 3'b000};

        // Two bus words side by side; the upper half is the second beat.
        st_vec = (2*BW)'(st_data) << {off, 3'b000};

        // For size == 2*BUS_BYTES the shift wraps to zero and the subtract
        // yields all ones, which is the intended full mask.
        size_mask = ((2*BUS_BYTES)'(1) << size) - (2*BUS_BYTES)'(1);
        strb_vec  = size_mask << off;

        ld_vec = {beat1, beat0} >> {off, 3'b000};
        ld_raw = ld_vec[XLEN-1:0];

        case (size)
            4'd1:    sign_bit = ld_raw[7];
            4'd2:    sign_bit = ld_raw[15];
            4'd4:    sign_bit = ld_raw[31];
            default: sign_bit = ld_raw[XLEN-1];
        endcase

        ld_data = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            ld_data[i] = (i < int'(nbits)) ? ld_raw[i] : (sgn & sign_bit);
        end
    end

    assign st_lo   = st_vec[BW-1:0];
    assign st_hi   = st_vec[2*BW-1:BW];
    assign strb_lo = strb_vec[BUS_BYTES-1:0];
    assign strb_hi = strb_vec[2*BUS_BYTES-1:BUS_BYTES];

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage between execute and writeback.
// Takes one instruction over in_valid/in_ready, issues one or two bus beats
// for loads/stores (splitting bus-word crossings when enabled), and presents
// the writeback result over out_valid/out_ready.
//   in_*      - instruction from execute (memr/memw select load/store/none)
//   out_*     - writeback result, fault flag and captured PC
//   bus_req_* - bus request (word-aligned address, lane data, byte strobes)
//   bus_resp_*- one response or write acknowledge per request
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned BUS_BYTES        = 4,
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_memr,
    input  logic                   in_memw,
    input  MemType                 in_memt,
    input  logic [XLEN-1:0]        in_addr,
    input  logic [XLEN-1:0]        in_wdata,
    input  logic [XLEN-1:0]        in_result,
    input  logic                   in_wback,
    input  logic [4:0]             in_wreg,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_wback,
    output logic [4:0]             out_wreg,
    output logic [XLEN-1:0]        out_wdata,
    output logic                   out_fault,
    output logic [XLEN-1:0]        out_pc,
    output logic                   bus_req_valid,
    input  logic                   bus_req_ready,
    output logic                   bus_req_we,
    output logic [XLEN-1:0]        bus_req_addr,
    output logic [8*BUS_BYTES-1:0] bus_req_wdata,
    output logic [BUS_BYTES-1:0]   bus_req_wstrb,
    input  logic                   bus_resp_valid,
    input  logic [8*BUS_BYTES-1:0] bus_resp_rdata
);

    localparam int unsigned OFFW = $clog2(BUS_BYTES);
    localparam int unsigned BW   = 8 * BUS_BYTES;

    MauState state_q, state_d;

    logic            memr_q, memw_q, wback_q, split_q;
    MemType          memt_q;
    logic [XLEN-1:0] addr_q, st_data_q;
    logic [BW-1:0]   beat0_q;
    logic [XLEN-1:0] out_wdata_q, out_pc_q;
    logic [4:0]      out_wreg_q;
    logic            out_wback_q, out_fault_q;

    // Accept-time decode.
    logic            accept, in_memop, in_cross, in_illegal, in_fault;
    logic [4:0]      in_end;

    always_comb begin
        in_memop   = in_memr | in_memw;
        in_end     = 5'(in_addr[OFFW-1:0]) + 5'(memt_size(in_memt));
        in_cross   = in_end > 5'(BUS_BYTES);
        // Accesses spanning more than two bus words cannot be split either.
        in_illegal = ((XLEN == 32) && memt_wide(in_memt))
                   || (in_end > 5'(2 * BUS_BYTES))
                   || (in_cross && (SPLIT_MISALIGNED == 0));
        in_fault   = in_memop & in_illegal;
        accept     = in_valid & in_ready;
    end

    // Lane steering on the captured instruction.
    logic [BW-1:0]        st_lo, st_hi, beat0_in, beat1_in;
    logic [BUS_BYTES-1:0] strb_lo, strb_hi;
    logic [XLEN-1:0]      ld_data;

    // On the final beat, beat0 comes from the register (split) or the bus.
    assign beat0_in = (state_q == RESP1) ? beat0_q : bus_resp_rdata;
    assign beat1_in = (state_q == RESP1) ? bus_resp_rdata : '0;

    mem_lane_align #(
        .XLEN      (XLEN),
        .BUS_BYTES (BUS_BYTES)
    ) u_lane (
        .memt    (memt_q),
        .off     (addr_q[OFFW-1:0]),
        .st_data (st_data_q),
        .st_lo   (st_lo),
        .st_hi   (st_hi),
        .strb_lo (strb_lo),
        .strb_hi (strb_hi),
        .beat0   (beat0_in),
        .beat1   (beat1_in),
        .ld_data (ld_data)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus request outputs.
    logic            beat_hi;
    logic [XLEN-1:0] word_addr;

    always_comb begin
        state_d       = state_q;
        bus_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (!in_memop || in_fault) ? OUT : REQ0;
                end
            end
            REQ0: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) state_d = RESP0;
            end
            RESP0: begin
                if (bus_resp_valid) state_d = split_q ? REQ1 : OUT;
            end
            REQ1: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) state_d = RESP1;
            end
            RESP1: begin
                if (bus_resp_valid) state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        beat_hi       = (state_q == REQ1);
        word_addr     = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
        bus_req_we    = bus_req_valid & memw_q;
        bus_req_addr  = '0;
        bus_req_wdata = '0;
        bus_req_wstrb = '0;
        if (bus_req_valid) begin
            bus_req_addr  = beat_hi ? (word_addr + XLEN'(BUS_BYTES)) : word_addr;
            bus_req_wdata = beat_hi ? st_hi : st_lo;
            bus_req_wstrb = beat_hi ? strb_hi : strb_lo;
        end
    end

    // Instruction capture and result formation.
    logic last_resp;
    assign last_resp = bus_resp_valid
                     && (((state_q == RESP0) && !split_q) || (state_q == RESP1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memr_q      <= 1'b0;
            memw_q      <= 1'b0;
            memt_q      <= LoadByte;
            wback_q     <= 1'b0;
            split_q     <= 1'b0;
            addr_q      <= '0;
            st_data_q   <= '0;
            beat0_q     <= '0;
            out_wdata_q <= '0;
            out_pc_q    <= '0;
            out_wreg_q  <= '0;
            out_wback_q <= 1'b0;
            out_fault_q <= 1'b0;
        end else begin
            if (accept) begin
                memr_q      <= in_memr;
                memw_q      <= in_memw;
                memt_q      <= in_memt;
                wback_q     <= in_wback;
                split_q     <= in_cross;
                addr_q      <= in_addr;
                st_data_q   <= in_wdata;
                out_pc_q    <= in_pc;
                out_wreg_q  <= in_wreg;
                out_fault_q <= in_fault;
                out_wback_q <= in_memop ? 1'b0 : in_wback;
                out_wdata_q <= in_memop ? '0 : in_result;
            end
            if ((state_q == RESP0) && bus_resp_valid) begin
                beat0_q <= bus_resp_rdata;
            end
            if (last_resp) begin
                out_wback_q <= memr_q & wback_q;
                out_wdata_q <= memr_q ? ld_data : '0;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_wback = out_wback_q;
    assign out_wreg  = out_wreg_q;
    assign out_wdata = out_wdata_q;
    assign out_fault = out_fault_q;
    assign out_pc    = out_pc_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised memory stage between execute and writeback. Accepts one instruction at a time over a valid/ready handshake and turns loads and stores into bus transactions. It handles byte-lane alignment, sign/zero extension, and splitting of accesses that cross a bus word. Non-memory instructions pass through with one cycle of latency.

Parameters:
XLEN, 32, register/address width; legal values are 32 and 64.
BUS_BYTES, 4, memory bus width in bytes; legal values are 4 and 8, and BUS_BYTES <= XLEN/8.
SPLIT_MISALIGNED, 1, selects handling of an access that crosses a bus-word boundary: 1 = split into two beats, 0 = raise a fault with no bus traffic.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction
in_memr / in_memw  in  1 each  load / store request; both 0 means pass-through
in_memt  in  Common::MemType  access type
in_addr  in  XLEN  effective byte address
in_wdata  in  XLEN  store data
in_result  in  XLEN  ALU result, used for pass-through
in_wback  in  1  writeback enable
in_wreg  in  5  destination register
in_pc  in  XLEN  instruction PC, used for fault reporting
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_wback  out  1  writeback enable
out_wreg  out  5  destination register
out_wdata  out  XLEN  writeback data
out_fault  out  1  misaligned or illegal access
out_pc  out  XLEN  captured PC
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts the request
bus_req_we  out  1  1 = write
bus_req_addr  out  XLEN  bus-word-aligned address
bus_req_wdata  out  8*BUS_BYTES  write data in lane position
bus_req_wstrb  out  BUS_BYTES  byte enables
bus_resp_valid  in  1  response or write acknowledge
bus_resp_rdata  in  8*BUS_BYTES  read data

Behaviour:
- Reset (async, immediate): state IDLE. All valid outputs, out_fault, out_wback and bus_req_we are 0; every data/address output is 0. in_ready is 1 from the first cycle after reset.
- States: IDLE, REQ0, RESP0, REQ1, RESP1, OUT.
- in_ready = (state == IDLE). An instruction is accepted on in_valid && in_ready; all inputs are captured.
- Transitions out of IDLE on accept:
  - memr = memw = 0: go to OUT with out_wdata = in_result, out_wback = in_wback.
  - Fault: go to OUT with out_fault = 1, out_wback = 0, out_wdata = 0. A fault is either (a) a crossing access when SPLIT_MISALIGNED = 0, or (b) LoadDouble, ULoadWord or StoreDouble when XLEN = 32.
  - Otherwise go to REQ0.
- REQ0: bus_req_valid = 1, bus_req_addr = addr & ~(BUS_BYTES-1). All request fields stay stable until bus_req_ready. On handshake go to RESP0.
- RESP0: wait for bus_resp_valid, then capture beat0 rdata. Next state is REQ1 if the access is split, else OUT.
- REQ1/RESP1: same as REQ0/RESP0 with address plus BUS_BYTES, capturing beat1.
- bus_resp_valid is ignored outside RESP0/RESP1 (simulation `err). A response never arrives in the same cycle as its request handshake. Exactly one response per request, including writes.
- Lane rules (off = addr mod BUS_BYTES, size = 1/2/4/8 from memt):
  - Store data: the 2*BUS_BYTES-byte vector wdata << 8*off. The low half is beat0 and the high half is beat1.
  - Strobe: ((1<<size)-1) << off, split the same way.
  - crossing = off + size > BUS_BYTES.
  - Load data: ({beat1, beat0} >> 8*off), truncated to size bytes, sign-extended for signed types and zero-extended for U types, to XLEN.
- Writeback flags: loads have out_wback = in_wback; stores have out_wback = 0 and out_wdata = 0.
- OUT: out_valid = 1 and all out_* are held stable until out_ready, then go to IDLE. The next instruction is not accepted in the same cycle (one bubble).
- Minimum latency with a zero-wait bus: pass-through gives out_valid at accept+1. Single-beat load: request at +1, response at +2 or later, out_valid the cycle after the response.
- Reset mid-operation abandons any in-flight request. The bus interconnect shares rst.

Decomposition:
- Common package:
  - extend MemType with LoadDouble, ULoadWord, StoreDouble;
  - functions memt_size(MemType) and memt_signed(MemType);
  - enum MauState.
- One combinational sub-module, mem_lane_align. It does the store shift/strobe generation and the load extract/extend. Parameters: XLEN, BUS_BYTES.

Test Plan:
- LoadByte at 0x1003, rdata 0x80000000 -> out_wdata 0xFFFFFF80. ULoadByte at the same address -> 0x00000080.
- StoreHalf at 0x1002, wdata 0x1234ABCD -> one request: addr 0x1000, wdata 0xABCD0000, wstrb 0b1100, we = 1. After the ack: out_wback = 0.
- LoadWord at 0x1003 with SPLIT = 1:
  - beat0 at addr 0x1000 returns rdata 0x44000000;
  - beat1 at addr 0x1004 returns rdata 0x00332211;
  - result out_wdata = 0x33221144.
- The same load with SPLIT = 0 -> no bus_req_valid, out_fault = 1, out_wback = 0, out_pc = in_pc.
- Backpressure: hold bus_req_ready low for 3 cycles -> request fields stable throughout. Then hold out_ready low for 2 cycles -> outputs stable and in_ready = 0.
- Assert rst while in RESP0 -> outputs 0 immediately. in_ready = 1 after release; a late bus_resp_valid is ignored. A pass-through of 0xDEADBEEF yields out_wdata 0xDEADBEEF one cycle after accept.
